// File: rtl/rvv_backend_mul_rs_pkg.sv
// Shared types and constants for the multiply/MAC reservation station.
package rvv_backend_mul_rs_pkg;

  // Number of uops exchanged per cycle with dispatch and with execute.
  localparam int NUM_MUL    = 2;
  localparam int NUM_DP_UOP = 2;

  // Multiply/MAC uop as held in the reservation station.
  typedef struct packed {
    logic [4:0]  vd_index;
    logic [2:0]  op;
    logic [31:0] rs1_data;
  } MUL_RS_t;

endpackage

// File: rtl/rvv_backend_multi_fifo.sv
// Multi-port circular FIFO: up to PUSH_N in-order pushes and POP_N in-order
// pops per cycle, combinational read of the POP_N oldest entries, and status
// flags decoded from the registered occupancy count.
module rvv_backend_multi_fifo #(
  parameter type DATA_T = logic [7:0],
  parameter int  DEPTH  = 8,
  parameter int  PUSH_N = 2,
  parameter int  POP_N  = 2,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic [PUSH_N-1:0] push_i,
  input  DATA_T             push_data_i [PUSH_N],
  input  logic [POP_N-1:0]  pop_i,
  output DATA_T             pop_data_o [POP_N],
  output logic              full_o,
  output logic              almost_full_o,
  output logic              empty_o,
  output logic              almost_empty_o
);

  DATA_T             mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PUSH_N-1:0] push_acc;
  logic [POP_N-1:0]  pop_acc;
  logic [CNT_W-1:0]  push_cnt, pop_cnt;

  // Push acceptance: each slot needs all older slots accepted and one more free
  // entry than the slot before it, judged on the pre-cycle count only.
  always_comb begin
    logic ok;
    ok       = !clear_i;
    push_acc = '0;
    push_cnt = '0;
    for (int i = 0; i < PUSH_N; i++) begin
      ok          = ok & push_i[i] & (count_q <= CNT_W'(DEPTH - 1 - i));
      push_acc[i] = ok;
      push_cnt    = push_cnt + CNT_W'(ok);
    end
  end

  // Pop acceptance: same prefix rule, each slot needs one more valid entry.
  always_comb begin
    logic ok;
    ok      = !clear_i;
    pop_acc = '0;
    pop_cnt = '0;
    for (int i = 0; i < POP_N; i++) begin
      ok         = ok & pop_i[i] & (count_q >= CNT_W'(i + 1));
      pop_acc[i] = ok;
      pop_cnt    = pop_cnt + CNT_W'(ok);
    end
  end

  // Next pointer/count values; pointer sums wrap because DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q + PTR_W'(push_cnt);
    rptr_d  = rptr_q + PTR_W'(pop_cnt);
    count_d = count_q + push_cnt - pop_cnt;
  end

  // Pointer and count registers; reset and clear both empty the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage, written at consecutive slots from wptr; never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PUSH_N; i++) begin
      if (push_acc[i]) begin
        mem_q[wptr_q + PTR_W'(i)] <= push_data_i[i];
      end
    end
  end

  // Oldest entries read straight from the array; slots past occupancy show 0.
  for (genvar gi = 0; gi < POP_N; gi++) begin : g_rd
    assign pop_data_o[gi] = (count_q > CNT_W'(gi)) ? mem_q[rptr_q + PTR_W'(gi)] : '0;
  end

  assign full_o         = (count_q == CNT_W'(DEPTH));
  assign almost_full_o  = (count_q == CNT_W'(DEPTH - 1));
  assign empty_o        = (count_q == '0);
  assign almost_empty_o = (count_q == CNT_W'(1));

`ifdef RVV_MUL_RS_SVA_EN
  a_count_le_depth: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CNT_W'(DEPTH));
`endif

endmodule

// File: rtl/rvv_backend_mul_rs.sv
// Reservation station for multiply/MAC uops between dispatch and the MUL/MAC
// execute wrapper. Optional protocol assertions: define RVV_MUL_RS_SVA_EN.
module rvv_backend_mul_rs
  import rvv_backend_mul_rs_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trap_flush_rvv,
  input  logic [NUM_MUL-1:0] dp2rs_push_valid,
  input  MUL_RS_t            dp2rs_push_data [NUM_MUL],
  output logic               rs2dp_fifo_full,
  output logic               rs2dp_fifo_1left_to_full,
  output MUL_RS_t            rs2ex_uop_data [NUM_MUL],
  output logic               rs2ex_fifo_empty,
  output logic               rs2ex_fifo_1left_to_empty,
  input  logic [NUM_MUL-1:0] ex2rs_fifo_pop
);

  // Flush reuses the FIFO clear path so it overrides same-cycle push and pop.
  rvv_backend_multi_fifo #(
    .DATA_T (MUL_RS_t),
    .DEPTH  (DEPTH),
    .PUSH_N (NUM_MUL),
    .POP_N  (NUM_MUL)
  ) u_fifo (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear_i        (trap_flush_rvv),
    .push_i         (dp2rs_push_valid),
    .push_data_i    (dp2rs_push_data),
    .pop_i          (ex2rs_fifo_pop),
    .pop_data_o     (rs2ex_uop_data),
    .full_o         (rs2dp_fifo_full),
    .almost_full_o  (rs2dp_fifo_1left_to_full),
    .empty_o        (rs2ex_fifo_empty),
    .almost_empty_o (rs2ex_fifo_1left_to_empty)
  );

`ifdef RVV_MUL_RS_SVA_EN
  a_push1_wo_push0: assert property (@(posedge clk) disable iff (!rst_n || trap_flush_rvv)
    !(dp2rs_push_valid[1] && !dp2rs_push_valid[0]));
  a_pop1_wo_pop0: assert property (@(posedge clk) disable iff (!rst_n || trap_flush_rvv)
    !(ex2rs_fifo_pop[1] && !ex2rs_fifo_pop[0]));
  a_push_when_full: assert property (@(posedge clk) disable iff (!rst_n || trap_flush_rvv)
    !(rs2dp_fifo_full && dp2rs_push_valid[0]));
  a_push2_at_1left: assert property (@(posedge clk) disable iff (!rst_n || trap_flush_rvv)
    !(rs2dp_fifo_1left_to_full && (dp2rs_push_valid == 2'b11)));
  a_pop_when_empty: assert property (@(posedge clk) disable iff (!rst_n || trap_flush_rvv)
    !(rs2ex_fifo_empty && ex2rs_fifo_pop[0]));
  a_pop2_at_1left: assert property (@(posedge clk) disable iff (!rst_n || trap_flush_rvv)
    !(rs2ex_fifo_1left_to_empty && (ex2rs_fifo_pop == 2'b11)));
  c_full_pop2: cover property (@(posedge clk) disable iff (!rst_n)
    rs2dp_fifo_full && (ex2rs_fifo_pop == 2'b11));
`endif

endmodule

// File: tb/tb_rvv_backend_mul_rs.sv
// Directed bench for rvv_backend_mul_rs: each step queues its hand-computed
// post-edge expectation, and a negedge monitor compares it against the DUT.
module tb_rvv_backend_mul_rs;
  import rvv_backend_mul_rs_pkg::*;

  // Expected flag patterns {empty, 1left_to_empty, full, 1left_to_full}
  localparam logic [3:0] E   = 4'b1000;
  localparam logic [3:0] ONE = 4'b0100;
  localparam logic [3:0] MID = 4'b0000;
  localparam logic [3:0] LF  = 4'b0001;
  localparam logic [3:0] F   = 4'b0010;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               trap_flush_rvv;
  logic [NUM_MUL-1:0] dp2rs_push_valid;
  MUL_RS_t            dp2rs_push_data [NUM_MUL];
  logic               rs2dp_fifo_full;
  logic               rs2dp_fifo_1left_to_full;
  MUL_RS_t            rs2ex_uop_data [NUM_MUL];
  logic               rs2ex_fifo_empty;
  logic               rs2ex_fifo_1left_to_empty;
  logic [NUM_MUL-1:0] ex2rs_fifo_pop;

  typedef struct {
    int         target;
    string      name;
    logic [3:0] flags;
    MUL_RS_t    d0;
    MUL_RS_t    d1;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   cycle    = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  rvv_backend_mul_rs #(.DEPTH(8)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .trap_flush_rvv            (trap_flush_rvv),
    .dp2rs_push_valid          (dp2rs_push_valid),
    .dp2rs_push_data           (dp2rs_push_data),
    .rs2dp_fifo_full           (rs2dp_fifo_full),
    .rs2dp_fifo_1left_to_full  (rs2dp_fifo_1left_to_full),
    .rs2ex_uop_data            (rs2ex_uop_data),
    .rs2ex_fifo_empty          (rs2ex_fifo_empty),
    .rs2ex_fifo_1left_to_empty (rs2ex_fifo_1left_to_empty),
    .ex2rs_fifo_pop            (ex2rs_fifo_pop)
  );

  // Tag n -> uop; tag 0 is the all-zero uop shown for unoccupied slots.
  function automatic MUL_RS_t mk(input int n);
    MUL_RS_t m;
    m.vd_index = n[4:0];
    m.op       = n[2:0];
    m.rs1_data = 32'(n) * 32'h0101_0101;
    return m;
  endfunction

  // Drive one cycle of inputs and queue the state expected after the edge.
  task automatic step(input string name, input logic rn, input logic fl,
                      input logic [1:0] pv, input int a, input int b,
                      input logic [1:0] pp, input logic [3:0] flags,
                      input int x0, input int x1);
    exp_t r;
    rst_n              = rn;
    trap_flush_rvv     = fl;
    dp2rs_push_valid   = pv;
    dp2rs_push_data[0] = mk(a);
    dp2rs_push_data[1] = mk(b);
    ex2rs_fifo_pop     = pp;
    r.target = cycle + 1;
    r.name   = name;
    r.flags  = flags;
    r.d0     = mk(x0);
    r.d1     = mk(x1);
    exp_q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued expectation on the negedge of its cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].target <= cycle) begin
      cur = exp_q.pop_front();
      n_checks++;
      if (cur.target != cycle) begin
        $display("FAIL %s: sampled late at cycle %0d, required cycle %0d", cur.name, cycle, cur.target);
      end else if ({rs2ex_fifo_empty, rs2ex_fifo_1left_to_empty, rs2dp_fifo_full,
                    rs2dp_fifo_1left_to_full} !== cur.flags ||
                   rs2ex_uop_data[0] !== cur.d0 || rs2ex_uop_data[1] !== cur.d1) begin
        $display("FAIL %s: flags=%b d0=%h d1=%h, required flags=%b d0=%h d1=%h", cur.name,
                 {rs2ex_fifo_empty, rs2ex_fifo_1left_to_empty, rs2dp_fifo_full,
                  rs2dp_fifo_1left_to_full}, rs2ex_uop_data[0], rs2ex_uop_data[1],
                 cur.flags, cur.d0, cur.d1);
      end else begin
        n_pass++;
        $display("ok   %s: flags=%b d0=%h d1=%h", cur.name, cur.flags, cur.d0, cur.d1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    trap_flush_rvv     = 1'b0;
    dp2rs_push_valid   = '0;
    dp2rs_push_data[0] = '0;
    dp2rs_push_data[1] = '0;
    ex2rs_fifo_pop     = '0;
    @(posedge clk);
    #1;

    // Reset state
    step("reset",        0, 0, 2'b00, 0, 0, 2'b00, E,   0, 0);
    // Single push, visible next cycle; slot 1 zero
    step("push_A",       1, 0, 2'b01, 1, 0, 2'b00, ONE, 1, 0);
    step("pop_A",        1, 0, 2'b00, 0, 0, 2'b01, E,   0, 0);
    // Push into empty with pop: not poppable the same cycle
    step("push_pop_emp", 1, 0, 2'b01, 2, 0, 2'b11, ONE, 2, 0);
    step("pop_2",        1, 0, 2'b00, 0, 0, 2'b01, E,   0, 0);
    // push_valid[1] alone is ignored
    step("push_hi_only", 1, 0, 2'b10, 7, 8, 2'b00, E,   0, 0);
    // Double pushes then double pops
    step("push_AB",      1, 0, 2'b11, 3, 4, 2'b00, MID, 3, 4);
    step("push_CD",      1, 0, 2'b11, 5, 6, 2'b00, MID, 3, 4);
    step("pop2_AB",      1, 0, 2'b00, 0, 0, 2'b11, MID, 5, 6);
    step("pop2_CD",      1, 0, 2'b00, 0, 0, 2'b11, E,   0, 0);
    // Fill to 7, then double push at DEPTH-1 accepts only slot 0
    step("fill_2",       1, 0, 2'b11, 10, 11, 2'b00, MID, 10, 11);
    step("fill_4",       1, 0, 2'b11, 12, 13, 2'b00, MID, 10, 11);
    step("fill_6",       1, 0, 2'b11, 14, 15, 2'b00, MID, 10, 11);
    step("fill_7",       1, 0, 2'b01, 16, 0,  2'b00, LF,  10, 11);
    step("push_XY_at7",  1, 0, 2'b11, 17, 18, 2'b00, F,   10, 11);
    // Full: pop 2 does not make room for same-cycle push
    step("full_push_pop",1, 0, 2'b11, 19, 20, 2'b11, MID, 12, 13);
    step("drain_4",      1, 0, 2'b00, 0, 0,  2'b11, MID, 14, 15);
    step("drain_2",      1, 0, 2'b00, 0, 0,  2'b11, MID, 16, 17);
    step("pop_hi_only",  1, 0, 2'b00, 0, 0,  2'b10, MID, 16, 17);
    step("drain_1",      1, 0, 2'b00, 0, 0,  2'b01, ONE, 17, 0);
    step("pop2_at_1",    1, 0, 2'b00, 0, 0,  2'b11, E,   0, 0);
    // Wrap-around: prefill 2, then alternate push 2 / pop 2 for 20 cycles
    step("wrap_pre",     1, 0, 2'b11, 98, 99, 2'b00, MID, 98, 99);
    for (int j = 0; j < 10; j++) begin
      step($sformatf("wrap_push%0d", j), 1, 0, 2'b11, 100 + 2*j, 101 + 2*j, 2'b00,
           MID, 98 + 2*j, 99 + 2*j);
      step($sformatf("wrap_pop%0d", j),  1, 0, 2'b00, 0, 0, 2'b11,
           MID, 100 + 2*j, 101 + 2*j);
    end
    step("wrap_drain",   1, 0, 2'b00, 0, 0, 2'b11, E, 0, 0);
    // Flush at count 5 with push and pop active
    step("fl_fill_2",    1, 0, 2'b11, 40, 41, 2'b00, MID, 40, 41);
    step("fl_fill_4",    1, 0, 2'b11, 42, 43, 2'b00, MID, 40, 41);
    step("fl_fill_5",    1, 0, 2'b01, 44, 0,  2'b00, MID, 40, 41);
    step("flush",        1, 1, 2'b11, 45, 46, 2'b11, E,   0, 0);
    step("post_flush",   1, 0, 2'b01, 47, 0,  2'b00, ONE, 47, 0);
    step("post_fl_pop",  1, 0, 2'b00, 0, 0,  2'b01, E,   0, 0);
    // Reset mid-operation, with flush and push also asserted
    step("rst_fill",     1, 0, 2'b11, 50, 51, 2'b00, MID, 50, 51);
    step("rst_mid",      0, 1, 2'b11, 52, 53, 2'b00, E,   0, 0);
    step("post_rst",     1, 0, 2'b01, 54, 0,  2'b00, ONE, 54, 0);
    step("post_rst_pop", 1, 0, 2'b00, 0, 0,  2'b01, E,   0, 0);

    dp2rs_push_valid = '0;
    ex2rs_fifo_pop   = '0;
    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations never compared, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
